sram_icb_ctrl: RTL and testbench

- ICB slave that acts as the initiator for the 1RW1R OpenRAM SRAM macro's RW port (port 0).
- Converts ICB command/response handshakes into macro controls (csb0/web0/wmask0/addr0/din0) and captures dout0 into a response buffer.
- Sits between the E203 bus fabric and the accelerator's local SRAM. The macro's port 1 is owned by other logic.

---
 rtl/sram_icb_ctrl.sv | 178 +++++++++++++++++
 tb/tb_sram_icb_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_icb_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_icb_ctrl: ICB slave driving the RW port of a 1RW1R OpenRAM macro,   |
// | with an in-order response FIFO. Optional zero-fill: SRAM_CTRL_ZERO_INIT_EN|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sram_icb_ctrl #(
  parameter int AW        = 32,
  parameter int RAM_AW    = 13,
  parameter int RSP_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icb_cmd_valid,
  output logic              icb_cmd_ready,
  input  logic [AW-1:0]     icb_cmd_addr,
  input  logic              icb_cmd_read,
  input  logic [31:0]       icb_cmd_wdata,
  input  logic [3:0]        icb_cmd_wmask,
  output logic              icb_rsp_valid,
  input  logic              icb_rsp_ready,
  output logic [31:0]       icb_rsp_rdata,
  output logic              icb_rsp_err,
  output logic              init_done,
  output logic              ram_csb0,
  output logic              ram_web0,
  output logic [3:0]        ram_wmask0,
  output logic [RAM_AW-1:0] ram_addr0,
  output logic [31:0]       ram_din0,
  input  logic [31:0]       ram_dout0
);

  localparam int                 c_PTR_W    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int                 c_CNT_W    = $clog2(RSP_DEPTH + 1);
  localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(RSP_DEPTH - 1);
  localparam logic [c_CNT_W:0]   c_OCC_MAX  = (c_CNT_W + 1)'(RSP_DEPTH);

  logic              w_oor;
  logic              w_hs;
  logic              w_push;
  logic              w_pop;
  logic              w_init_done;
  logic              w_init_active;
  logic [RAM_AW-1:0] w_init_addr;
  logic [c_CNT_W:0]  w_occ;
  logic [1:0]        w_unused_addr;

  logic               r_pend;
  logic               r_pend_read;
  logic               r_pend_err;
  logic [31:0]        r_fifo_rdata [RSP_DEPTH];
  logic               r_fifo_err   [RSP_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_cnt;

  function automatic logic [c_PTR_W-1:0] f_ptr_next(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  generate
    if (AW > RAM_AW + 2) begin : g_oor_chk
      assign w_oor = |icb_cmd_addr[AW-1:RAM_AW+2];
    end else begin : g_oor_none
      assign w_oor = 1'b0;
    end
  endgenerate

  assign w_unused_addr = icb_cmd_addr[1:0];

  // Acceptance only looks at registered occupancy, never at icb_rsp_ready.
  assign w_occ         = {1'b0, r_cnt} + {{c_CNT_W{1'b0}}, r_pend};
  assign icb_cmd_ready = rst_n & w_init_done & (w_occ < c_OCC_MAX);
  assign w_hs          = icb_cmd_valid & icb_cmd_ready;
  assign init_done     = w_init_done;

  always_comb begin
    ram_csb0   = ~(w_hs & ~w_oor);
    ram_web0   = icb_cmd_read;
    ram_wmask0 = icb_cmd_wmask;
    ram_addr0  = icb_cmd_addr[RAM_AW+1:2];
    ram_din0   = icb_cmd_wdata;
    if (w_init_active) begin
      ram_csb0   = ~rst_n;
      ram_web0   = 1'b0;
      ram_wmask0 = 4'hF;
      ram_addr0  = w_init_addr;
      ram_din0   = 32'h0;
    end
  end

`ifdef SRAM_CTRL_ZERO_INIT_EN
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [RAM_AW-1:0] r_init_cnt;
  logic [RAM_AW-1:0] w_init_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    w_init_active  = 1'b0;
    w_init_done    = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_init_active  = 1'b1;
        w_init_cnt_nxt = r_init_cnt + 1'b1;
        if (r_init_cnt == {RAM_AW{1'b1}}) w_state_nxt = ST_RUN;
      end
      ST_RUN: w_init_done = 1'b1;
    endcase
  end

  assign w_init_addr = r_init_cnt;
`else
  assign w_init_done   = 1'b1;
  assign w_init_active = 1'b0;
  assign w_init_addr   = '0;
`endif

  // The macro's read data appears one cycle after the handshake; pend marks that slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend      <= 1'b0;
      r_pend_read <= 1'b0;
      r_pend_err  <= 1'b0;
    end else begin
      r_pend      <= w_hs;
      r_pend_read <= icb_cmd_read & ~w_oor;
      r_pend_err  <= w_oor;
    end
  end

  assign w_push        = r_pend;
  assign w_pop         = icb_rsp_valid & icb_rsp_ready;
  assign icb_rsp_valid = (r_cnt != '0);
  assign icb_rsp_rdata = r_fifo_rdata[r_rd_ptr];
  assign icb_rsp_err   = r_fifo_err[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rdata[r_wr_ptr] <= r_pend_read ? ram_dout0 : 32'h0;
      r_fifo_err[r_wr_ptr]   <= r_pend_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= f_ptr_next(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_ptr_next(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_icb_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sram_icb_ctrl: self-checking bench with SRAM macro model and a        |
// | transaction-level reference (memory image + expected-response queue).   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sram_icb_ctrl;

`ifdef SRAM_CTRL_ZERO_INIT_EN
  localparam int c_RAM_AW = 4;
`else
  localparam int c_RAM_AW = 13;
`endif
  localparam int          c_DEPTH = 1 << c_RAM_AW;
  localparam int          c_RSP   = 3;
  localparam logic [31:0] c_TA    = (c_RAM_AW >= 5) ? 32'h40 : 32'h20;
  localparam logic [31:0] c_OOR   = 32'h0001_0000;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
  logic [31:0]         icb_cmd_addr, icb_cmd_wdata;
  logic [3:0]          icb_cmd_wmask;
  logic                icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
  logic [31:0]         icb_rsp_rdata;
  logic                init_done;
  logic                ram_csb0, ram_web0;
  logic [3:0]          ram_wmask0;
  logic [c_RAM_AW-1:0] ram_addr0;
  logic [31:0]         ram_din0;
  logic [31:0]         ram_dout0 = 32'h0;

  sram_icb_ctrl #(.AW(32), .RAM_AW(c_RAM_AW), .RSP_DEPTH(c_RSP)) dut (
    .clk(clk), .rst_n(rst_n),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
    .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
    .init_done(init_done),
    .ram_csb0(ram_csb0), .ram_web0(ram_web0), .ram_wmask0(ram_wmask0),
    .ram_addr0(ram_addr0), .ram_din0(ram_din0), .ram_dout0(ram_dout0)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f_pat(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'hC3A5_0F1E;
  endfunction

  // Macro model: samples on posedge, commits writes on the following negedge.
  logic [31:0]         sram [c_DEPTH];
  logic                s_we = 1'b0;
  logic [3:0]          s_mask;
  logic [c_RAM_AW-1:0] s_addr;
  logic [31:0]         s_din;
  logic                do_preload;

  always @(posedge clk) begin
    s_we <= 1'b0;
    if (!ram_csb0) begin
      if (!ram_web0) begin
        s_we <= 1'b1; s_mask <= ram_wmask0; s_addr <= ram_addr0; s_din <= ram_din0;
      end else begin
        ram_dout0 <= sram[ram_addr0];
      end
    end
  end

  always @(negedge clk) begin
    if (do_preload) begin
      for (int i = 0; i < c_DEPTH; i++) sram[i] = f_pat(i);
    end else if (s_we) begin
      for (int b = 0; b < 4; b++)
        if (s_mask[b]) sram[s_addr][8*b +: 8] = s_din[8*b +: 8];
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          ready_at;
  } exp_t;

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  exp_t        q[$];
  logic [31:0] ref_mem [c_DEPTH];
  vec_t        vecs [8];
  int          tests, fails, cyc;
  logic        accepted, popped, last_err;
  logic [31:0] last_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One bus cycle: compare at negedge against the reference, then let the posedge happen.
  task automatic step();
    logic                exp_valid, oor;
    logic [c_RAM_AW-1:0] idx;
    exp_t                e;
    @(negedge clk);
    cyc++;
    accepted = 1'b0;
    popped   = 1'b0;
    check("cmd_ready", icb_cmd_ready, q.size() < c_RSP);
    exp_valid = (q.size() > 0) && (q[0].ready_at <= cyc);
    check("rsp_valid", icb_rsp_valid, exp_valid);
    if (icb_rsp_valid && q.size() > 0) begin
      check("rsp_rdata", icb_rsp_rdata, q[0].rdata);
      check("rsp_err", icb_rsp_err, q[0].err);
      if (icb_rsp_ready) begin
        last_rdata = icb_rsp_rdata;
        last_err   = icb_rsp_err;
        popped     = 1'b1;
        void'(q.pop_front());
      end
    end
    if (icb_cmd_valid && icb_cmd_ready) begin
      accepted = 1'b1;
      oor = (icb_cmd_addr >> (c_RAM_AW + 2)) != 0;
      idx = icb_cmd_addr[c_RAM_AW+1:2];
      check("ram_csb0", ram_csb0, oor);
      if (!oor) begin
        check("ram_addr0", 32'(ram_addr0), 32'(idx));
        check("ram_web0", ram_web0, icb_cmd_read);
        if (!icb_cmd_read) begin
          check("ram_din0", ram_din0, icb_cmd_wdata);
          check("ram_wmask0", 32'(ram_wmask0), 32'(icb_cmd_wmask));
        end
      end
      e.err      = oor;
      e.rdata    = (icb_cmd_read && !oor) ? ref_mem[idx] : 32'h0;
      e.ready_at = cyc + 2;
      if (!icb_cmd_read && !oor)
        for (int b = 0; b < 4; b++)
          if (icb_cmd_wmask[b]) ref_mem[idx][8*b +: 8] = icb_cmd_wdata[8*b +: 8];
      q.push_back(e);
    end else begin
      check("ram_csb0_idle", ram_csb0, 1'b1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int n;
    icb_cmd_valid = 1'b1; icb_cmd_read = v.rd; icb_cmd_addr = v.addr;
    icb_cmd_wdata = v.wdata; icb_cmd_wmask = v.wmask; icb_rsp_ready = 1'b1;
    n = 0;
    do begin step(); n++; end while (!accepted && n < 20);
    icb_cmd_valid = 1'b0;
    check($sformatf("vec%0d_accept", k), accepted, 1'b1);
    n = 0;
    do begin step(); n++; end while (!popped && n < 20);
    check($sformatf("vec%0d_latency", k), n, 2);
    check($sformatf("vec%0d_rdata", k), last_rdata, v.exp_rdata);
    check($sformatf("vec%0d_err", k), last_err, v.exp_err);
  endtask

  task automatic b2b_reads(input int cnt, input logic chk_zero);
    int issued, pops;
    issued = 0; pops = 0;
    icb_rsp_ready = 1'b1;
    for (int s = 0; s < cnt + 2; s++) begin
      icb_cmd_valid = (issued < cnt);
      icb_cmd_read  = 1'b1;
      icb_cmd_addr  = 32'(issued) << 2;
      step();
      if (s < cnt) check("b2b_accept", accepted, 1'b1);
      if (accepted) issued++;
      if (popped) begin
        pops++;
        if (chk_zero) check("zero_rdata", last_rdata, 32'h0);
      end
    end
    icb_cmd_valid = 1'b0;
    check("b2b_pops", pops, cnt);
  endtask

`ifdef SRAM_CTRL_ZERO_INIT_EN
  task automatic init_watch(input int stop_at, output int rise);
    rise = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (init_done) begin
        rise = n;
        return;
      end
      check("init_addr", 32'(ram_addr0), 32'(n));
      check("init_csb0", ram_csb0, 1'b0);
      check("init_web0", ram_web0, 1'b0);
      check("init_wmask", 32'(ram_wmask0), 32'hF);
      check("init_din", ram_din0, 32'h0);
      check("init_ready", icb_cmd_ready, 1'b0);
      if (n == stop_at) return;
    end
  endtask
`endif

  initial begin
    int rise, acc, maxw;
    logic [31:0] a;
    tests = 0; fails = 0; cyc = 0;
    rst_n = 1'b0; do_preload = 1'b1;
    icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = 32'h0;
    icb_cmd_wdata = 32'h0; icb_cmd_wmask = 4'h0; icb_rsp_ready = 1'b1;
    for (int i = 0; i < c_DEPTH; i++) ref_mem[i] = f_pat(i);
    repeat (3) @(posedge clk);
    do_preload = 1'b0;
    #1;
    check("rst_csb0", ram_csb0, 1'b1);
    check("rst_cmd_ready", icb_cmd_ready, 1'b0);
    check("rst_rsp_valid", icb_rsp_valid, 1'b0);
`ifdef SRAM_CTRL_ZERO_INIT_EN
    check("rst_init_done", init_done, 1'b0);
    icb_cmd_valid = 1'b0;
    rst_n = 1'b1;
    init_watch(5, rise);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst2_csb0", ram_csb0, 1'b1);
    check("rst2_init_done", init_done, 1'b0);
    rst_n = 1'b1;
    init_watch(-1, rise);
    check("init_rise", rise, 16);
    @(posedge clk); #1;
    for (int i = 0; i < c_DEPTH; i++) ref_mem[i] = 32'h0;
    b2b_reads(c_DEPTH, 1'b1);
`else
    check("rst_init_done", init_done, 1'b1);
    icb_cmd_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", icb_cmd_ready, 1'b1);
    check("post_rst_valid", icb_rsp_valid, 1'b0);
`endif

    vecs[0] = '{1'b0, c_TA,  32'hDEAD_BEEF, 4'hF,    32'h0,         1'b0};
    vecs[1] = '{1'b1, c_TA,  32'h0,         4'h0,    32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b0, c_TA,  32'h0000_AB00, 4'b0010, 32'h0,         1'b0};
    vecs[3] = '{1'b1, c_TA,  32'h0,         4'h0,    32'hDEAD_ABEF, 1'b0};
    vecs[4] = '{1'b1, c_OOR, 32'h0,         4'h0,    32'h0,         1'b1};
    vecs[5] = '{1'b0, c_TA,  32'hFFFF_FFFF, 4'h0,    32'h0,         1'b0};
    vecs[6] = '{1'b1, c_TA,  32'h0,         4'h0,    32'hDEAD_ABEF, 1'b0};
    vecs[7] = '{1'b0, c_OOR, 32'h1234_5678, 4'hF,    32'h0,         1'b1};
    for (int k = 0; k < 8; k++) run_vec(vecs[k], k);

    b2b_reads(8, 1'b0);

    // Backpressure: responses stalled while commands keep being offered.
    acc = 0;
    icb_rsp_ready = 1'b0; icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1;
    for (int s = 0; s < 6; s++) begin
      icb_cmd_addr = 32'(acc) << 2;
      step();
      if (accepted) acc++;
    end
    check("stall_accepted", acc, 3);
    check("stall_ready", icb_cmd_ready, 1'b0);
    icb_cmd_valid = 1'b0; icb_rsp_ready = 1'b1;
    acc = 0;
    for (int s = 0; s < 6; s++) begin
      step();
      if (popped) acc++;
    end
    check("stall_drained", acc, 3);
    check("stall_ready_back", icb_cmd_ready, 1'b1);

    maxw = (c_DEPTH > 64) ? 64 : c_DEPTH;
    for (int k = 0; k < 400; k++) begin
      a = (32'($urandom_range(0, maxw - 1)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(31, c_RAM_AW + 2));
      icb_cmd_valid = ($urandom_range(0, 3) != 0);
      icb_cmd_read  = $urandom_range(0, 1) != 0;
      icb_cmd_addr  = a;
      icb_cmd_wdata = $urandom;
      icb_cmd_wmask = 4'($urandom_range(0, 15));
      icb_rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    icb_cmd_valid = 1'b0; icb_rsp_ready = 1'b1;
    for (int s = 0; s < 10 && q.size() > 0; s++) step();
    check("final_drain", q.size(), 0);
    check("final_rsp_valid", icb_rsp_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
